// File: rtl/uart_pkg.sv
// Shared types for the UART sort/transmit slice: controller and transmitter
// state encodings, byte width and the sort-order compare helper.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SORT     = 3'd1,
    ST_TX_ISSUE = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } ctrl_state_e;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_STOP    = 3'd3,
    TX_CLEANUP = 3'd4
  } tx_state_e;

  // Strict compare only, so equal bytes stay put and the sort is stable.
  function automatic logic needs_swap(input logic [BYTE_W-1:0] a,
                                      input logic [BYTE_W-1:0] b,
                                      input logic              ascend);
    return ascend ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/uart_sort_buf.sv
// Byte register file for the sort controller: one write port, one
// compare-swap port on adjacent entries (idx, idx+1) and one read port.
module uart_sort_buf
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ASCEND = 1,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [IW-1:0]     cmp_idx,
  input  logic              swap_en,
  output logic              swap_needed,
  input  logic [IW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem_r [0:(2**IW)-1];
  logic [IW-1:0]     nxt_idx_s;

  assign nxt_idx_s   = cmp_idx + IW'(1);
  assign swap_needed = needs_swap(mem_r[cmp_idx], mem_r[nxt_idx_s], (ASCEND != 0));
  assign rd_data     = mem_r[rd_addr];

  // Storage update: loads and swaps never coincide (IDLE vs SORT)
  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else if (swap_en) begin
      mem_r[cmp_idx]   <= mem_r[nxt_idx_s];
      mem_r[nxt_idx_s] <= mem_r[cmp_idx];
    end
  end

endmodule

// File: rtl/uart_sort_tx_ctrl.sv
// Collects a burst of bytes, bubble-sorts them in place, then feeds them one
// at a time to uart_tx, pacing on its active/done handshake.
module uart_sort_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ASCEND = 1,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Load_DV,
  input  logic [BYTE_W-1:0] i_Load_Byte,
  input  logic              i_Start,
  output logic              o_Busy,
  output logic [CW-1:0]     o_Count,
  output logic              o_Load_Err,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Done
);

  localparam int IW = $clog2(DEPTH);

  ctrl_state_e       state_r, state_s;
  logic [CW-1:0]     count_r, count_s, p_r, p_s, j_r, j_s, k_r, k_s, last_j_s;
  logic              swapped_r, swapped_s;
  logic              tx_done_prev_r, tx_done_rise_s;
  logic              wr_en_s, swap_en_s, swap_needed_s;
  logic [BYTE_W-1:0] rd_data_s, tx_byte_r, tx_byte_s;
  logic              busy_r, load_err_r, load_err_s, tx_dv_r, tx_dv_s, done_r;

  assign tx_done_rise_s = i_Tx_Done & ~tx_done_prev_r;
  assign last_j_s       = count_r - CW'(2) - p_r;

  uart_sort_buf #(
    .DEPTH  (DEPTH),
    .ASCEND (ASCEND),
    .IW     (IW)
  ) u_buf (
    .i_Clock     (i_Clock),
    .wr_en       (wr_en_s),
    .wr_addr     (count_r[IW-1:0]),
    .wr_data     (i_Load_Byte),
    .cmp_idx     (j_r[IW-1:0]),
    .swap_en     (swap_en_s),
    .swap_needed (swap_needed_s),
    .rd_addr     (k_r[IW-1:0]),
    .rd_data     (rd_data_s)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    p_s        = p_r;
    j_s        = j_r;
    k_s        = k_r;
    swapped_s  = swapped_r;
    wr_en_s    = 1'b0;
    swap_en_s  = 1'b0;
    load_err_s = 1'b0;
    tx_dv_s    = 1'b0;
    tx_byte_s  = tx_byte_r;
    case (state_r)
      ST_IDLE: begin
        if (i_Load_DV) begin
          if (count_r < CW'(DEPTH)) begin
            wr_en_s = 1'b1;
            count_s = count_r + CW'(1);
          end else begin
            load_err_s = 1'b1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
        // Start decision uses the post-load count so a same-cycle byte is included
        if (i_Start) begin
          p_s       = '0;
          j_s       = '0;
          k_s       = '0;
          swapped_s = 1'b0;
          if (count_s >= CW'(2)) begin
            state_s = ST_SORT;
          end else if (count_s == CW'(1)) begin
            state_s = ST_TX_ISSUE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SORT: begin
        swap_en_s = swap_needed_s;
        if (j_r == last_j_s) begin
          if (!(swapped_r | swap_needed_s) || (p_r == count_r - CW'(2))) begin
            state_s = ST_TX_ISSUE;
            k_s     = '0;
          end else begin
            p_s       = p_r + CW'(1);
            j_s       = '0;
            swapped_s = 1'b0;
          end
        end else begin
          j_s       = j_r + CW'(1);
          swapped_s = swapped_r | swap_needed_s;
        end
      end
      ST_TX_ISSUE: begin
        if (!i_Tx_Active && !i_Tx_Done) begin
          tx_dv_s   = 1'b1;
          tx_byte_s = rd_data_s;
          state_s   = ST_TX_WAIT;
        end else begin
          state_s = ST_TX_ISSUE;
        end
      end
      ST_TX_WAIT: begin
        if (tx_done_rise_s) begin
          if (k_r == count_r - CW'(1)) begin
            state_s = ST_DONE;
          end else begin
            k_s     = k_r + CW'(1);
            state_s = ST_TX_ISSUE;
          end
        end else begin
          state_s = ST_TX_WAIT;
        end
      end
      ST_DONE: begin
        count_s = '0;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (i_Load_DV && (state_r != ST_IDLE)) begin
      load_err_s = 1'b1;
    end else begin
      load_err_s = load_err_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r        <= ST_IDLE;
      count_r        <= '0;
      p_r            <= '0;
      j_r            <= '0;
      k_r            <= '0;
      swapped_r      <= 1'b0;
      tx_done_prev_r <= 1'b1;
      busy_r         <= 1'b0;
      load_err_r     <= 1'b0;
      tx_dv_r        <= 1'b0;
      tx_byte_r      <= 8'h00;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      count_r        <= count_s;
      p_r            <= p_s;
      j_r            <= j_s;
      k_r            <= k_s;
      swapped_r      <= swapped_s;
      tx_done_prev_r <= i_Tx_Done;
      busy_r         <= (state_s != ST_IDLE);
      load_err_r     <= load_err_s;
      tx_dv_r        <= tx_dv_s;
      tx_byte_r      <= tx_byte_s;
      done_r         <= (state_s == ST_DONE);
    end
  end

  assign o_Busy     = busy_r;
  assign o_Count    = count_r;
  assign o_Load_Err = load_err_r;
  assign o_Tx_DV    = tx_dv_r;
  assign o_Tx_Byte  = tx_byte_r;
  assign o_Done     = done_r;

endmodule

// File: tb/tb_uart_sort_tx_ctrl.sv
// Directed bench for uart_sort_tx_ctrl with a behavioural uart_tx model
// (CLKS_PER_BIT=4, adjustable done-hold length).
module tb_uart_sort_tx_ctrl;
  import uart_pkg::*;

  localparam int FRAME = 10 * 4;

  logic       clk = 1'b0;
  logic       i_Reset, i_Load_DV, i_Start, m_rst;
  logic [7:0] i_Load_Byte;
  logic       o_Busy, o_Load_Err, o_Tx_DV, o_Done;
  logic [3:0] o_Count;
  logic [7:0] o_Tx_Byte;
  logic       tx_active, tx_done;

  tx_state_e  m_st;
  int         m_cnt;
  int         done_hold = 1;
  int         dv_cnt = 0;
  int         viol = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_sort_tx_ctrl dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Load_DV   (i_Load_DV),
    .i_Load_Byte (i_Load_Byte),
    .i_Start     (i_Start),
    .o_Busy      (o_Busy),
    .o_Count     (o_Count),
    .o_Load_Err  (o_Load_Err),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Done      (o_Done)
  );

  // uart_tx model: one frame of FRAME clocks, then done held for done_hold clocks
  always @(posedge clk or posedge m_rst) begin
    if (m_rst) begin
      m_st      <= TX_IDLE;
      m_cnt     <= 0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      if (o_Tx_DV) begin
        dv_cnt <= dv_cnt + 1;
        tx_q.push_back(o_Tx_Byte);
        if (m_st != TX_IDLE || tx_done) viol <= viol + 1;
      end
      case (m_st)
        TX_IDLE: if (o_Tx_DV) begin
          m_st      <= TX_DATA;
          tx_active <= 1'b1;
          m_cnt     <= FRAME - 1;
        end
        TX_DATA: if (m_cnt == 0) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          m_st      <= TX_CLEANUP;
          m_cnt     <= done_hold - 1;
        end else m_cnt <= m_cnt - 1;
        TX_CLEANUP: if (m_cnt == 0) begin
          tx_done <= 1'b0;
          m_st    <= TX_IDLE;
        end else m_cnt <= m_cnt - 1;
        default: m_st <= TX_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_count"}, o_Count, 0);
    check({tag, "_load_err"}, o_Load_Err, 0);
    check({tag, "_tx_dv"}, o_Tx_DV, 0);
    check({tag, "_tx_byte"}, o_Tx_Byte, 8'h00);
    check({tag, "_done"}, o_Done, 0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_Load_DV = 1'b1;
    i_Load_Byte = b;
    @(negedge clk);
    i_Load_DV = 1'b0;
  endtask

  task automatic wait_dv();
    int n = 0;
    while (!o_Tx_DV && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dv_seen", o_Tx_DV, 1);
  endtask

  // Start, optionally measure SORT length, wait for o_Done and compare the byte stream to exp_q
  task automatic run_burst(input int exp_sort, input bit ld_in_wait);
    int n;
    int dv0;
    dv0 = dv_cnt;
    tx_q.delete();
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    i_Load_DV = 1'b0;
    check("busy_after_start", o_Busy, 1);
    if (exp_sort >= 0) begin
      n = 0;
      while (!o_Tx_DV && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("sort_cycles", n - 1, exp_sort);
      if (ld_in_wait) begin
        load_byte(8'h5A);
        check("load_err_busy", o_Load_Err, 1);
        check("count_busy", o_Count, exp_q.size());
      end
    end
    n = 0;
    while (!o_Done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", o_Done, 1);
    check("dv_pulses", dv_cnt - dv0, exp_q.size());
    if (exp_q.size() > 0) check("tx_byte_hold", o_Tx_Byte, exp_q[exp_q.size()-1]);
    @(negedge clk);
    check("done_cleared", o_Done, 0);
    check("busy_cleared", o_Busy, 0);
    check("count_cleared", o_Count, 0);
    check("tx_len", tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check("tx_byte", tx_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] byte_v;
    logic       st;
    logic [3:0] cnt;
    logic       err;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    int dv0;
    // ld, byte, start | count, load_err, busy, done
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[3+i] = '{1'b1, 8'(7 - i), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0};

    i_Reset = 1'b1; m_rst = 1'b1;
    i_Load_DV = 1'b0; i_Load_Byte = 8'h00; i_Start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    i_Reset = 1'b0; m_rst = 1'b0;

    dv0 = dv_cnt;
    for (int i = 0; i < 13; i++) begin
      i_Load_DV = tbl[i].ld;
      i_Load_Byte = tbl[i].byte_v;
      i_Start = tbl[i].st;
      @(negedge clk);
      i_Load_DV = 1'b0;
      i_Start = 1'b0;
      check($sformatf("v%0d_count", i), o_Count, tbl[i].cnt);
      check($sformatf("v%0d_load_err", i), o_Load_Err, tbl[i].err);
      check($sformatf("v%0d_busy", i), o_Busy, tbl[i].busy);
      check($sformatf("v%0d_done", i), o_Done, tbl[i].done);
    end
    check("empty_start_no_dv", dv_cnt - dv0, 0);

    // Reverse-ordered eight bytes already loaded by the table
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    run_burst(28, 1'b0);

    // Already sorted
    for (int i = 0; i < 8; i++) load_byte(8'(i));
    run_burst(7, 1'b0);

    load_byte(8'h30); load_byte(8'h10); load_byte(8'h20);
    exp_q = '{8'h10, 8'h20, 8'h30};
    run_burst(3, 1'b0);

    // Single byte with load and start in the same cycle, then a load while busy
    i_Load_DV = 1'b1;
    i_Load_Byte = 8'hA5;
    exp_q = '{8'hA5};
    run_burst(0, 1'b1);

    // Done held for two cycles per frame
    done_hold = 2;
    viol = 0;
    load_byte(8'h03); load_byte(8'h01); load_byte(8'h02);
    exp_q = '{8'h01, 8'h02, 8'h03};
    run_burst(3, 1'b0);
    check("no_dv_during_done", viol, 0);
    done_hold = 1;

    // Reset during SORT
    for (int i = 0; i < 8; i++) load_byte(8'(7 - i));
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (5) @(negedge clk);
    i_Reset = 1'b1;
    #1;
    check_reset("rst_sort");
    @(negedge clk);
    i_Reset = 1'b0;

    // Reset during TX_WAIT
    load_byte(8'h44); load_byte(8'h22);
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    wait_dv();
    @(negedge clk);
    check("tx_byte_before_rst", o_Tx_Byte, 8'h22);
    i_Reset = 1'b1;
    #1;
    check_reset("rst_wait");
    @(negedge clk);
    i_Reset = 1'b0;
    n = 0;
    while ((tx_active || tx_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("model_idle", {tx_active, tx_done}, 2'b00);
    check("count_after_rst", o_Count, 0);

    load_byte(8'h30); load_byte(8'h10); load_byte(8'h20);
    exp_q = '{8'h10, 8'h20, 8'h30};
    run_burst(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
